// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions: register index width, register count
// and the ID issue-controller state encoding.
package arm_pipe_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/id_hazard_scoreboard_sb_entry.sv
// One scoreboard slot: counts the advancing cycles until an in-flight
// write-back to this register has landed in the register file.
module sb_entry #(
    parameter int WB_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    input  logic load,
    output logic busy
);

    localparam int CNT_W = $clog2(WB_LAT + 1);

    logic [CNT_W-1:0] cnt;

    // A new write re-arms the slot even if it is still counting down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (adv) begin
            if (load) begin
                cnt <= CNT_W'(WB_LAT);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage issue controller: register scoreboard, freeze/bubble
// generation and taken-branch flush sequencing.
module id_hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter int NUM_REGS  = arm_pipe_pkg::NUM_REGS,
    parameter int WB_LAT    = 3,
    parameter int FLUSH_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [3:0]           id_src1,
    input  logic                 id_src1_used,
    input  logic [3:0]           id_src2,
    input  logic                 id_src2_used,
    input  logic                 id_wb_en,
    input  logic [3:0]           id_dest,
    input  logic                 exe_br_taken,
    input  logic                 mem_busy,
    output logic                 id_issue,
    output logic                 freeze,
    output logic                 bubble,
    output logic                 flush,
    output logic [NUM_REGS-1:0]  pending_mask,
    output logic [15:0]          stall_cnt
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    logic                adv;
    logic                run;
    logic                hazard;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] load;
    state_t              state;
    state_t              state_nxt;
    logic [FC_W-1:0]     fcnt;
    logic [FC_W-1:0]     fcnt_nxt;

    assign adv = ~mem_busy;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        sb_entry #(
            .WB_LAT(WB_LAT)
        ) u_entry (
            .clk (clk),
            .rst (rst),
            .adv (adv),
            .load(load[r]),
            .busy(busy[r])
        );
    end

    assign pending_mask = busy;

    always_comb begin
        load = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            load[r] = id_issue & id_wb_en
                    & (id_dest == REG_IDX_W'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // A branch arriving while already flushing cannot happen; it is ignored.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (adv) begin
            unique case (state)
                RUN: begin
                    if (exe_br_taken && FLUSH_CYC > 0) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FC_W'(FLUSH_CYC - 1);
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        fcnt_nxt = fcnt - FC_W'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        run      = (state == RUN);
        hazard   = id_valid & run
                 & ((id_src1_used & busy[id_src1])
                  | (id_src2_used & busy[id_src2]));
        id_issue = adv & id_valid & run & ~hazard & ~exe_br_taken;
        freeze   = mem_busy | hazard;
        bubble   = adv & (hazard | exe_br_taken | ~run);
        flush    = adv & (exe_br_taken | ~run);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (adv && hazard && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
